complex_nr_acc: RTL and testbench

Downstream consumer of the complex multiplier result stream. It accepts one complex product per handshake and accumulates a programmable number of products into wide signed real/imaginary sums, for dot products and correlation. When a frame is complete it presents one result beat on a valid/ready output port. It connects directly to the multiplier's res_val/res_ready/result_re/result_im.

---
 rtl/complex_nr_acc_if.sv | 30 +++
 rtl/complex_nr_acc.sv | 123 ++++++++++++
 tb/tb_complex_nr_acc.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/complex_nr_acc_if.sv
// Stream bundle between the complex multiplier and complex_nr_acc.
// Input side: in_val/in_ready with a complex product (in_re/in_im) and the frame length acc_len.
// Output side: out_val/out_ready with the accumulated sums (out_re/out_im) and the overflow flag.
// The slave modport is the accumulator; the master modport is its environment.
interface complex_nr_acc_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 8,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                      in_val;
  logic                      in_ready;
  logic [2*DATA_WIDTH-1:0]   in_re;
  logic [2*DATA_WIDTH-1:0]   in_im;
  logic [CNT_WIDTH-1:0]      acc_len;
  logic                      out_val;
  logic                      out_ready;
  logic [ACC_WIDTH-1:0]      out_re;
  logic [ACC_WIDTH-1:0]      out_im;
  logic                      out_ovf;

  modport slave (
    input  in_val, in_re, in_im, acc_len, out_ready,
    output in_ready, out_val, out_re, out_im, out_ovf
  );

  modport master (
    output in_val, in_re, in_im, acc_len, out_ready,
    input  in_ready, out_val, out_re, out_im, out_ovf
  );
endinterface

// File: rtl/complex_nr_acc.sv
// Complex product accumulator: sums acc_len products (0 means 1) into wide signed real/imaginary
// accumulators and presents one result beat per frame, with a sticky signed-overflow flag.
// Ports: clk (rising edge), sw_rst (synchronous, active high), bus (slave modport of
// complex_nr_acc_if carrying the product input stream and the result output stream).
module complex_nr_acc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic              clk,
  input logic              sw_rst,
  complex_nr_acc_if.slave  bus
);
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned XW = ACC_WIDTH - PW;

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [ACC_WIDTH-1:0]   out_re_q, out_re_d, out_im_q, out_im_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, len_q, len_d;
  logic                   ovf_q, ovf_d, out_ovf_q, out_ovf_d;

  logic [ACC_WIDTH-1:0]   ext_re, ext_im, sum_re, sum_im;
  logic                   ov_re, ov_im, ovf_new;
  logic [CNT_WIDTH-1:0]   cnt_inc, len_in;
  logic                   in_xfer;

  assign ext_re  = {{XW{bus.in_re[PW-1]}}, bus.in_re};
  assign ext_im  = {{XW{bus.in_im[PW-1]}}, bus.in_im};
  assign sum_re  = acc_re_q + ext_re;
  assign sum_im  = acc_im_q + ext_im;
  // Signed overflow: operands agree in sign, sum does not.
  assign ov_re   = (acc_re_q[ACC_WIDTH-1] == ext_re[ACC_WIDTH-1]) &&
                   (sum_re[ACC_WIDTH-1] != acc_re_q[ACC_WIDTH-1]);
  assign ov_im   = (acc_im_q[ACC_WIDTH-1] == ext_im[ACC_WIDTH-1]) &&
                   (sum_im[ACC_WIDTH-1] != acc_im_q[ACC_WIDTH-1]);
  assign ovf_new = ovf_q | ov_re | ov_im;
  assign cnt_inc = cnt_q + 1'b1;
  assign len_in  = (bus.acc_len == '0) ? CNT_WIDTH'(1) : bus.acc_len;

  // Handshake outputs decode the state only.
  assign bus.in_ready = (state_q != StHold);
  assign bus.out_val  = (state_q == StHold);
  assign bus.out_re   = out_re_q;
  assign bus.out_im   = out_im_q;
  assign bus.out_ovf  = out_ovf_q;
  assign in_xfer      = bus.in_val && (state_q != StHold);

  always_comb begin
    state_d   = state_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    out_re_d  = out_re_q;
    out_im_d  = out_im_q;
    out_ovf_d = out_ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          len_d    = len_in;
          acc_re_d = ext_re;
          acc_im_d = ext_im;
          cnt_d    = CNT_WIDTH'(1);
          ovf_d    = 1'b0;
          if (len_in == CNT_WIDTH'(1)) begin
            state_d   = StHold;
            out_re_d  = ext_re;
            out_im_d  = ext_im;
            out_ovf_d = 1'b0;
          end else begin
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (in_xfer) begin
          acc_re_d = sum_re;
          acc_im_d = sum_im;
          cnt_d    = cnt_inc;
          ovf_d    = ovf_new;
          if (cnt_inc == len_q) begin
            state_d   = StHold;
            out_re_d  = sum_re;
            out_im_d  = sum_im;
            out_ovf_d = ovf_new;
          end
        end
      end
      StHold: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q   <= StIdle;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
      out_ovf_q <= out_ovf_d;
    end
  end
endmodule

// File: tb/tb_complex_nr_acc.sv
module tb_complex_nr_acc;
  logic clk = 1'b0;
  logic sw_rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  complex_nr_acc_if #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus0 ();
  complex_nr_acc_if #(.DATA_WIDTH(8), .ACC_WIDTH(17), .CNT_WIDTH(8)) bus1 ();

  complex_nr_acc #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut0 (
    .clk    (clk),
    .sw_rst (sw_rst),
    .bus    (bus0)
  );

  complex_nr_acc #(.DATA_WIDTH(8), .ACC_WIDTH(17), .CNT_WIDTH(8)) dut1 (
    .clk    (clk),
    .sw_rst (sw_rst),
    .bus    (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send0(input logic [15:0] re, input logic [15:0] im);
    bus0.in_val = 1'b1;
    bus0.in_re  = re;
    bus0.in_im  = im;
    tick();
  endtask

  initial begin
    sw_rst         = 1'b1;
    bus0.in_val    = 1'b0;
    bus0.in_re     = '0;
    bus0.in_im     = '0;
    bus0.acc_len   = '0;
    bus0.out_ready = 1'b1;
    bus1.in_val    = 1'b0;
    bus1.in_re     = '0;
    bus1.in_im     = '0;
    bus1.acc_len   = '0;
    bus1.out_ready = 1'b1;
    tick();
    tick();
    sw_rst = 1'b0;

    // Reset state
    check("rst_in_ready", bus0.in_ready, 1);
    check("rst_out_val", bus0.out_val, 0);
    check("rst_out_re", bus0.out_re, 0);
    check("rst_out_im", bus0.out_im, 0);
    check("rst_out_ovf", bus0.out_ovf, 0);

    // Frame of 4, back to back
    bus0.acc_len = 8'd4;
    send0(16'd100, 16'hFFFF);
    check("t1_no_val_early", bus0.out_val, 0);
    send0(16'd200, 16'hFFFF);
    send0(16'd300, 16'hFFFF);
    send0(16'd400, 16'hFFFF);
    bus0.in_val = 1'b0;
    check("t1_out_val", bus0.out_val, 1);
    check("t1_in_ready_hold", bus0.in_ready, 0);
    check("t1_out_re", bus0.out_re, 24'd1000);
    check("t1_out_im", bus0.out_im, 24'hFFFFFC);
    check("t1_out_ovf", bus0.out_ovf, 0);
    tick();
    check("t1_val_drop", bus0.out_val, 0);
    check("t1_re_kept", bus0.out_re, 24'd1000);

    // acc_len=0 treated as 1
    bus0.acc_len = 8'd0;
    send0(16'h7FFF, 16'h8000);
    bus0.in_val = 1'b0;
    check("t2_out_val", bus0.out_val, 1);
    check("t2_out_re", bus0.out_re, 24'h007FFF);
    check("t2_out_im", bus0.out_im, 24'hFF8000);
    tick();

    // Back-pressure in HOLD with in_val held high
    bus0.out_ready = 1'b0;
    bus0.acc_len   = 8'd2;
    send0(16'd1, 16'd2);
    send0(16'd3, 16'd4);
    bus0.in_re = 16'd50;
    bus0.in_im = 16'd50;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_val", bus0.out_val, 1);
      check("t3_hold_rdy", bus0.in_ready, 0);
      check("t3_hold_re", bus0.out_re, 24'd4);
      check("t3_hold_im", bus0.out_im, 24'd6);
      tick();
    end
    bus0.out_ready = 1'b1;
    bus0.in_val    = 1'b0;
    tick();
    check("t3_rdy_after", bus0.in_ready, 1);
    check("t3_val_after", bus0.out_val, 0);
    // The blocked sample must not have started a frame: a len-1 frame yields exactly this sample
    bus0.acc_len = 8'd1;
    send0(16'd9, 16'd0);
    bus0.in_val = 1'b0;
    check("t3_no_stale", bus0.out_re, 24'd9);
    tick();

    // Overflow on the 17-bit instance
    bus1.acc_len = 8'd3;
    bus1.in_val  = 1'b1;
    bus1.in_re   = 16'h7FFF;
    bus1.in_im   = 16'h0000;
    tick();
    tick();
    tick();
    bus1.in_val = 1'b0;
    check("t4_out_val", bus1.out_val, 1);
    check("t4_out_ovf", bus1.out_ovf, 1);
    check("t4_out_re", bus1.out_re, 17'h17FFD);
    check("t4_out_im", bus1.out_im, 0);
    tick();

    // Reset mid-frame
    bus0.acc_len = 8'd3;
    send0(16'd10, 16'd10);
    send0(16'd10, 16'd10);
    bus0.in_val = 1'b0;
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("t5_rdy", bus0.in_ready, 1);
    check("t5_val", bus0.out_val, 0);
    check("t5_re", bus0.out_re, 0);
    check("t5_im", bus0.out_im, 0);
    bus0.acc_len = 8'd2;
    send0(16'd5, 16'd0);
    send0(16'd7, 16'd0);
    bus0.in_val = 1'b0;
    check("t5_out_val", bus0.out_val, 1);
    check("t5_out_re", bus0.out_re, 24'd12);
    tick();

    // Gaps and a mid-frame acc_len change
    bus0.acc_len = 8'd3;
    send0(16'd1, 16'hFFFE);
    bus0.acc_len = 8'd1;
    bus0.in_val  = 1'b0;
    tick();
    tick();
    send0(16'd2, 16'hFFFD);
    bus0.in_val = 1'b0;
    check("t6_not_done", bus0.out_val, 0);
    tick();
    send0(16'd3, 16'hFFFC);
    bus0.in_val = 1'b0;
    check("t6_out_val", bus0.out_val, 1);
    check("t6_out_re", bus0.out_re, 24'd6);
    check("t6_out_im", bus0.out_im, 24'hFFFFF7);

    // Reset during HOLD clears out_val
    bus0.out_ready = 1'b0;
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("t7_val_clr", bus0.out_val, 0);
    check("t7_re_clr", bus0.out_re, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
